// File: rtl/fft_mem_pkg.sv
// Shared types and default sizes for the FFT sample-memory arbiter slice.
package fft_mem_pkg;

    localparam int unsigned DATA_W_DEF        = 32;
    localparam int unsigned BANK_AW_DEF       = 10;
    localparam int unsigned HOST_MAX_WAIT_DEF = 8;
    localparam int unsigned WAIT_W            = 8;
    localparam int unsigned MEM_RD_LATENCY    = 1;

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        HOST   = 2'd1,
        ENGINE = 2'd2
    } owner_e;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        DRAIN = 2'd1,
        SWAP  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/fft_rd_tag_pipe.sv
// Owner-tag shift register that follows granted reads through the memory
// pipeline and raises the matching rvalid when the data comes back.
module fft_rd_tag_pipe
    import fft_mem_pkg::*;
(
    input  logic   pclk_i,
    input  logic   preset_n_i,
    input  owner_e tag_i,
    output logic   host_rvalid_o,
    output logic   eng_rvalid_o,
    output logic   pipe_empty_o
);

    localparam int unsigned DEPTH = MEM_RD_LATENCY + 1;

    owner_e tag_q [DEPTH];
    owner_e tag_d [DEPTH];

    always_comb begin
        tag_d[0] = tag_i;
        for (int i = 1; i < DEPTH; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    always_ff @(posedge pclk_i or negedge preset_n_i) begin
        if (!preset_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i] <= NONE;
            end
        end else begin
            tag_q <= tag_d;
        end
    end

    assign host_rvalid_o = (tag_q[DEPTH-1] == HOST);
    assign eng_rvalid_o  = (tag_q[DEPTH-1] == ENGINE);

    // The last stage retires in the current cycle, so only earlier stages
    // can keep the pipe occupied past the next edge.
    always_comb begin
        pipe_empty_o = 1'b1;
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (tag_q[i] != NONE) begin
                pipe_empty_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/fft_mem_arbiter.sv
// Single-port FFT sample memory arbiter: host/engine arbitration, ping-pong
// bank ownership and drained buffer swaps.
module fft_mem_arbiter
    import fft_mem_pkg::*;
#(
    parameter int unsigned DATA_W        = DATA_W_DEF,
    parameter int unsigned BANK_AW       = BANK_AW_DEF,
    parameter int unsigned HOST_MAX_WAIT = HOST_MAX_WAIT_DEF
) (
    input  logic               pclk_i,
    input  logic               preset_n_i,
    input  logic               fft_busy_i,
    input  logic               host_req_i,
    input  logic               host_we_i,
    input  logic [BANK_AW-1:0] host_addr_i,
    input  logic [DATA_W-1:0]  host_wdata_i,
    output logic               host_gnt_o,
    output logic               host_rvalid_o,
    output logic [DATA_W-1:0]  host_rdata_o,
    input  logic               eng_req_i,
    input  logic               eng_we_i,
    input  logic [BANK_AW-1:0] eng_addr_i,
    input  logic [DATA_W-1:0]  eng_wdata_i,
    output logic               eng_gnt_o,
    output logic               eng_rvalid_o,
    output logic [DATA_W-1:0]  eng_rdata_o,
    input  logic               swap_req_i,
    output logic               swap_ack_o,
    output logic               active_bank_o,
    output logic               mem_en_o,
    output logic               mem_we_o,
    output logic [BANK_AW:0]   mem_addr_o,
    output logic [DATA_W-1:0]  mem_wdata_o,
    input  logic [DATA_W-1:0]  mem_rdata_i
);

    localparam int unsigned       MEM_AW        = BANK_AW + 1;
    localparam logic [WAIT_W-1:0] WAIT_MAX      = '1;
    localparam logic [WAIT_W-1:0] HOST_WAIT_LIM = WAIT_W'(HOST_MAX_WAIT);

    arb_state_e          state_q, state_d;
    logic                bank_q, bank_d;
    owner_e              last_grant_q, last_grant_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                swap_ack_q, swap_ack_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic [MEM_AW-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

    logic                host_gnt_c, eng_gnt_c;
    owner_e              rd_tag_c;
    logic                pipe_empty_c;
    logic                drained_c;

    // Grant selection: a pending swap or a non-ARB state blocks all grants.
    always_comb begin
        host_gnt_c = 1'b0;
        eng_gnt_c  = 1'b0;
        if ((state_q == ARB) && !swap_req_i) begin
            if (host_req_i && eng_req_i) begin
                if (fft_busy_i) begin
                    host_gnt_c = (wait_cnt_q >= HOST_WAIT_LIM);
                end else begin
                    host_gnt_c = (last_grant_q == ENGINE);
                end
                eng_gnt_c = !host_gnt_c;
            end else begin
                host_gnt_c = host_req_i;
                eng_gnt_c  = eng_req_i;
            end
        end
    end

    assign drained_c = !mem_en_q && pipe_empty_c;

    always_comb begin
        state_d      = state_q;
        bank_d       = bank_q;
        last_grant_d = last_grant_q;
        wait_cnt_d   = wait_cnt_q;
        swap_ack_d   = 1'b0;
        mem_en_d     = host_gnt_c || eng_gnt_c;
        mem_we_d     = 1'b0;
        mem_addr_d   = '0;
        mem_wdata_d  = '0;
        rd_tag_c     = NONE;

        // Host always lands in the inactive bank, the engine in the active one.
        if (host_gnt_c) begin
            mem_we_d     = host_we_i;
            mem_addr_d   = {~bank_q, host_addr_i};
            mem_wdata_d  = host_wdata_i;
            last_grant_d = HOST;
            rd_tag_c     = host_we_i ? NONE : HOST;
        end else if (eng_gnt_c) begin
            mem_we_d     = eng_we_i;
            mem_addr_d   = {bank_q, eng_addr_i};
            mem_wdata_d  = eng_wdata_i;
            last_grant_d = ENGINE;
            rd_tag_c     = eng_we_i ? NONE : ENGINE;
        end

        if (!host_req_i || host_gnt_c) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != WAIT_MAX) begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end

        case (state_q)
            ARB: begin
                if (swap_req_i) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (drained_c) begin
                    state_d    = SWAP;
                    bank_d     = ~bank_q;
                    swap_ack_d = 1'b1;
                end
            end
            SWAP:    state_d = ARB;
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge pclk_i or negedge preset_n_i) begin
        if (!preset_n_i) begin
            state_q      <= ARB;
            bank_q       <= 1'b0;
            last_grant_q <= ENGINE;
            wait_cnt_q   <= '0;
            swap_ack_q   <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            bank_q       <= bank_d;
            last_grant_q <= last_grant_d;
            wait_cnt_q   <= wait_cnt_d;
            swap_ack_q   <= swap_ack_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    fft_rd_tag_pipe u_rd_tag_pipe (
        .pclk_i        (pclk_i),
        .preset_n_i    (preset_n_i),
        .tag_i         (rd_tag_c),
        .host_rvalid_o (host_rvalid_o),
        .eng_rvalid_o  (eng_rvalid_o),
        .pipe_empty_o  (pipe_empty_c)
    );

    assign host_gnt_o    = host_gnt_c;
    assign eng_gnt_o     = eng_gnt_c;
    assign swap_ack_o    = swap_ack_q;
    assign active_bank_o = bank_q;
    assign mem_en_o      = mem_en_q;
    assign mem_we_o      = mem_we_q;
    assign mem_addr_o    = mem_addr_q;
    assign mem_wdata_o   = mem_wdata_q;
    assign host_rdata_o  = host_rvalid_o ? mem_rdata_i : '0;
    assign eng_rdata_o   = eng_rvalid_o ? mem_rdata_i : '0;

endmodule

// File: tb/tb_fft_mem_arbiter.sv
// Directed bench for fft_mem_arbiter with a behavioural memory and a
// read-return scoreboard.
module tb_fft_mem_arbiter;

    logic        pclk_i;
    logic        preset_n_i;
    logic        fft_busy_i;
    logic        host_req_i, host_we_i;
    logic [9:0]  host_addr_i;
    logic [31:0] host_wdata_i;
    logic        host_gnt_o, host_rvalid_o;
    logic [31:0] host_rdata_o;
    logic        eng_req_i, eng_we_i;
    logic [9:0]  eng_addr_i;
    logic [31:0] eng_wdata_i;
    logic        eng_gnt_o, eng_rvalid_o;
    logic [31:0] eng_rdata_o;
    logic        swap_req_i, swap_ack_o, active_bank_o;
    logic        mem_en_o, mem_we_o;
    logic [10:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata;

    fft_mem_arbiter dut (
        .pclk_i        (pclk_i),
        .preset_n_i    (preset_n_i),
        .fft_busy_i    (fft_busy_i),
        .host_req_i    (host_req_i),
        .host_we_i     (host_we_i),
        .host_addr_i   (host_addr_i),
        .host_wdata_i  (host_wdata_i),
        .host_gnt_o    (host_gnt_o),
        .host_rvalid_o (host_rvalid_o),
        .host_rdata_o  (host_rdata_o),
        .eng_req_i     (eng_req_i),
        .eng_we_i      (eng_we_i),
        .eng_addr_i    (eng_addr_i),
        .eng_wdata_i   (eng_wdata_i),
        .eng_gnt_o     (eng_gnt_o),
        .eng_rvalid_o  (eng_rvalid_o),
        .eng_rdata_o   (eng_rdata_o),
        .swap_req_i    (swap_req_i),
        .swap_ack_o    (swap_ack_o),
        .active_bank_o (active_bank_o),
        .mem_en_o      (mem_en_o),
        .mem_we_o      (mem_we_o),
        .mem_addr_o    (mem_addr_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_rdata_i   (mem_rdata)
    );

    typedef struct packed {
        logic        is_host;
        logic [31:0] data;
    } exp_t;

    exp_t        sb_q [$];
    logic [31:0] mem_arr [2048];
    logic [31:0] ref_mem [2048];
    logic        exp_bank;
    int          checks = 0;
    int          errors = 0;

    initial pclk_i = 1'b0;
    always #5 pclk_i = ~pclk_i;

    // Behavioural single-port memory, one-cycle read latency.
    always @(posedge pclk_i) begin
        if (mem_en_o) begin
            if (mem_we_o) mem_arr[mem_addr_o] <= mem_wdata_o;
            else          mem_rdata <= mem_arr[mem_addr_o];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge pclk_i);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic push_rd(input logic is_host, input logic [10:0] a);
        exp_t e;
        e.is_host = is_host;
        e.data    = ref_mem[a];
        sb_q.push_back(e);
    endtask

    // Read-return scoreboard.
    always @(negedge pclk_i) begin
        if (preset_n_i && (host_rvalid_o || eng_rvalid_o)) begin
            exp_t e;
            chk("rv_both", 64'(host_rvalid_o && eng_rvalid_o), 64'd0);
            if (sb_q.size() == 0) begin
                chk("rv_unexpected", 64'd1, 64'd0);
            end else begin
                e = sb_q.pop_front();
                chk("rv_owner", 64'(host_rvalid_o), 64'(e.is_host));
                chk("rv_data", 64'(host_rvalid_o ? host_rdata_o : eng_rdata_o), 64'(e.data));
            end
        end
    end

    initial begin
        int gnt_cnt;
        int en_cnt;
        int mism;
        logic [9:0]  ra;
        logic [31:0] rd;

        preset_n_i = 1'b0;
        fft_busy_i = 1'b0;
        host_req_i = 1'b0; host_we_i = 1'b0; host_addr_i = '0; host_wdata_i = '0;
        eng_req_i  = 1'b0; eng_we_i  = 1'b0; eng_addr_i  = '0; eng_wdata_i  = '0;
        swap_req_i = 1'b0;
        mem_rdata  = '0;
        exp_bank   = 1'b0;
        for (int i = 0; i < 2048; i++) begin
            mem_arr[i] = 32'hC0DE0000 | 32'(i);
            ref_mem[i] = 32'hC0DE0000 | 32'(i);
        end

        repeat (2) cyc();
        chk("rst_host_gnt", 64'(host_gnt_o), 64'd0);
        chk("rst_mem_en", 64'(mem_en_o), 64'd0);
        chk("rst_bank", 64'(active_bank_o), 64'd0);
        chk("rst_swap_ack", 64'(swap_ack_o), 64'd0);
        chk("rst_rvalid", 64'({host_rvalid_o, eng_rvalid_o}), 64'd0);
        preset_n_i = 1'b1;

        // Idle tie after reset: host first, then engine.
        cyc(); host_req_i = 1; host_addr_i = 10'h012; eng_req_i = 1; eng_addr_i = 10'h034; settle();
        chk("t1_c0_host_gnt", 64'(host_gnt_o), 64'd1);
        chk("t1_c0_eng_gnt", 64'(eng_gnt_o), 64'd0);
        push_rd(1'b1, {~exp_bank, 10'h012});
        cyc(); host_req_i = 0; settle();
        chk("t1_c1_eng_gnt", 64'(eng_gnt_o), 64'd1);
        chk("t1_c1_mem_en", 64'(mem_en_o), 64'd1);
        chk("t1_c1_mem_addr", 64'(mem_addr_o), 64'h412);
        chk("t1_c1_mem_we", 64'(mem_we_o), 64'd0);
        push_rd(1'b0, {exp_bank, 10'h034});
        cyc(); eng_req_i = 0; settle();
        chk("t1_c2_mem_addr", 64'(mem_addr_o), 64'h034);
        chk("t1_c2_host_rvalid", 64'(host_rvalid_o), 64'd1);
        chk("t1_c2_eng_rvalid", 64'(eng_rvalid_o), 64'd0);
        cyc(); settle();
        chk("t1_c3_eng_rvalid", 64'(eng_rvalid_o), 64'd1);
        chk("t1_c3_host_rvalid", 64'(host_rvalid_o), 64'd0);

        // Busy engine starves host until the wait limit.
        fft_busy_i = 1;
        for (int k = 0; k < 10; k++) begin
            cyc();
            eng_req_i = 1; eng_we_i = 0; eng_addr_i = 10'(k);
            host_req_i = (k <= 8); host_we_i = 0; host_addr_i = 10'h055;
            settle();
            if (k == 8) begin
                chk("t2_host_wins", 64'(host_gnt_o), 64'd1);
                chk("t2_eng_loses", 64'(eng_gnt_o), 64'd0);
                push_rd(1'b1, {~exp_bank, 10'h055});
            end else begin
                chk("t2_eng_wins", 64'(eng_gnt_o), 64'd1);
                chk("t2_host_waits", 64'(host_gnt_o), 64'd0);
                push_rd(1'b0, {exp_bank, 10'(k)});
            end
        end
        cyc(); host_req_i = 1; eng_addr_i = 10'h00A; settle();
        chk("t2_wait_cleared", 64'({host_gnt_o, eng_gnt_o}), 64'b01);
        push_rd(1'b0, {exp_bank, 10'h00A});
        // Busy falls with a tie: round-robin, engine went last.
        cyc(); fft_busy_i = 0; host_addr_i = 10'h066; settle();
        chk("t2_busy_fall_tie", 64'({host_gnt_o, eng_gnt_o}), 64'b10);
        push_rd(1'b1, {~exp_bank, 10'h066});
        cyc(); host_req_i = 0; eng_req_i = 0;
        repeat (3) cyc();

        // Host write, swap, engine reads it back from the new active bank.
        cyc(); host_req_i = 1; host_we_i = 1; host_addr_i = 10'd5; host_wdata_i = 32'hDEADBEEF; settle();
        chk("t3_host_wr_gnt", 64'(host_gnt_o), 64'd1);
        ref_mem[{~exp_bank, 10'd5}] = 32'hDEADBEEF;
        cyc(); host_req_i = 0; host_we_i = 0; swap_req_i = 1; eng_req_i = 1; eng_we_i = 0; eng_addr_i = 10'd5; settle();
        chk("t3_wr_issue", 64'({mem_en_o, mem_we_o, mem_addr_o}), 64'({1'b1, 1'b1, 11'h405}));
        chk("t3_wr_data", 64'(mem_wdata_o), 64'hDEADBEEF);
        chk("t3_swap_outranks", 64'(eng_gnt_o), 64'd0);
        cyc(); settle();
        chk("t3_drain_no_gnt", 64'({host_gnt_o, eng_gnt_o}), 64'd0);
        chk("t3_drain_no_ack", 64'(swap_ack_o), 64'd0);
        cyc(); swap_req_i = 0; settle();
        chk("t3_swap_ack", 64'(swap_ack_o), 64'd1);
        chk("t3_bank", 64'(active_bank_o), 64'd1);
        chk("t3_swap_no_gnt", 64'(eng_gnt_o), 64'd0);
        exp_bank = 1'b1;
        cyc(); settle();
        chk("t3_ack_single", 64'(swap_ack_o), 64'd0);
        chk("t3_eng_gnt", 64'(eng_gnt_o), 64'd1);
        push_rd(1'b0, {exp_bank, 10'd5});
        cyc(); eng_req_i = 0; settle();
        chk("t3_rd_issue", 64'({mem_en_o, mem_addr_o}), 64'({1'b1, 11'h405}));
        cyc(); settle();
        chk("t3_eng_rvalid", 64'(eng_rvalid_o), 64'd1);
        chk("t3_eng_rdata", 64'(eng_rdata_o), 64'hDEADBEEF);

        // Reset with two reads in flight.
        cyc(); host_req_i = 1; host_addr_i = 10'h020; settle();
        chk("t5_host_gnt", 64'(host_gnt_o), 64'd1);
        push_rd(1'b1, {~exp_bank, 10'h020});
        cyc(); host_req_i = 0; eng_req_i = 1; eng_addr_i = 10'h021; settle();
        chk("t5_eng_gnt", 64'(eng_gnt_o), 64'd1);
        push_rd(1'b0, {exp_bank, 10'h021});
        cyc(); eng_req_i = 0; preset_n_i = 0; sb_q.delete(); exp_bank = 1'b0; settle();
        chk("t5_rst_gnts", 64'({host_gnt_o, eng_gnt_o}), 64'd0);
        chk("t5_rst_rvalid", 64'({host_rvalid_o, eng_rvalid_o}), 64'd0);
        chk("t5_rst_mem", 64'({mem_en_o, mem_we_o, mem_addr_o}), 64'd0);
        chk("t5_rst_wdata", 64'(mem_wdata_o), 64'd0);
        chk("t5_rst_rdata", 64'({host_rdata_o, eng_rdata_o}), 64'd0);
        chk("t5_rst_bank", 64'({active_bank_o, swap_ack_o}), 64'd0);
        cyc(); preset_n_i = 1;
        for (int k = 0; k < 4; k++) begin
            cyc(); settle();
            chk("t5_no_rvalid", 64'({host_rvalid_o, eng_rvalid_o}), 64'd0);
        end
        cyc(); host_req_i = 1; host_addr_i = 10'h030; eng_req_i = 1; eng_addr_i = 10'h031; settle();
        chk("t5_tie_host", 64'({host_gnt_o, eng_gnt_o}), 64'b10);
        push_rd(1'b1, {~exp_bank, 10'h030});
        cyc(); host_req_i = 0; settle();
        chk("t5_eng_next", 64'(eng_gnt_o), 64'd1);
        push_rd(1'b0, {exp_bank, 10'h031});
        cyc(); eng_req_i = 0;
        repeat (3) cyc();

        // Swap right after an engine read grant.
        cyc(); eng_req_i = 1; eng_addr_i = 10'd7; settle();
        chk("t4_eng_gnt", 64'(eng_gnt_o), 64'd1);
        push_rd(1'b0, {exp_bank, 10'd7});
        cyc(); eng_req_i = 0; swap_req_i = 1; host_req_i = 1; host_we_i = 0; host_addr_i = 10'd9; settle();
        chk("t4_swap_cycle_no_gnt", 64'({host_gnt_o, eng_gnt_o}), 64'd0);
        cyc(); settle();
        chk("t4_drain_no_gnt", 64'(host_gnt_o), 64'd0);
        chk("t4_drain_rvalid", 64'(eng_rvalid_o), 64'd1);
        chk("t4_drain_no_ack", 64'(swap_ack_o), 64'd0);
        cyc(); swap_req_i = 0; settle();
        chk("t4_swap_ack", 64'(swap_ack_o), 64'd1);
        chk("t4_bank", 64'(active_bank_o), 64'd1);
        chk("t4_swap_no_gnt", 64'(host_gnt_o), 64'd0);
        exp_bank = 1'b1;
        cyc(); settle();
        chk("t4_ack_single", 64'(swap_ack_o), 64'd0);
        chk("t4_host_gnt", 64'(host_gnt_o), 64'd1);
        push_rd(1'b1, {~exp_bank, 10'd9});
        cyc(); host_req_i = 0; settle();
        chk("t4_host_addr", 64'(mem_addr_o), 64'h009);
        repeat (3) cyc();

        // 100 back-to-back random host writes.
        gnt_cnt = 0;
        en_cnt  = 0;
        for (int i = 0; i < 100; i++) begin
            cyc();
            ra = 10'($urandom_range(0, 1023));
            rd = $urandom;
            host_req_i = 1; host_we_i = 1; host_addr_i = ra; host_wdata_i = rd;
            settle();
            if (host_gnt_o) gnt_cnt++;
            if (mem_en_o) en_cnt++;
            ref_mem[{~exp_bank, ra}] = rd;
        end
        cyc(); host_req_i = 0; host_we_i = 0; settle();
        if (mem_en_o) en_cnt++;
        cyc(); settle();
        chk("t6_tail_idle", 64'(mem_en_o), 64'd0);
        chk("t6_grants", 64'(gnt_cnt), 64'd100);
        chk("t6_mem_en", 64'(en_cnt), 64'd100);
        mism = 0;
        for (int j = 0; j < 2048; j++) begin
            if (mem_arr[j] !== ref_mem[j]) mism++;
        end
        chk("t6_mem_contents", 64'(mism), 64'd0);

        repeat (2) cyc();
        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
